// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: handshaked command sequencer for an 8-bit ALU datapath.
// Commands are queued in a small FIFO. Each command is driven onto the ALU
// ports from registers and held for SETTLE cycles. The ALU result is then
// captured and returned over a valid/ready response channel.
module alu_cmd_driver #(
  parameter int DEPTH  = 4,  // FIFO entries, power of two, >= 2
  parameter int SETTLE = 1   // ALU settle cycles, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_cin,
  // ALU-facing ports
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  op,
  output logic        F,
  input  logic [7:0]  R,
  input  logic        D,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_cout,
  output logic [3:0]  rsp_op,
  // status
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       cin;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // sequencer state and registered outputs
  state_t        r_state;
  logic [SW-1:0] r_settle;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [3:0]    r_op;
  logic          r_f;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_result;
  logic          r_rsp_cout;
  logic [3:0]    r_rsp_op;
  logic [15:0]   r_op_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_rsp_hs;
  cmd_t w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Held low during reset so every output reads 0 while rst is asserted.
  assign cmd_ready = ~rst & ~w_full;
  assign w_push   = cmd_valid & cmd_ready;
  assign w_rsp_hs = (r_state == ST_RESP) & r_rsp_valid & rsp_ready;
  // The head is consumed when idle or on a response handshake, so
  // back-to-back commands never pass through IDLE.
  assign w_pop    = ~w_empty & ((r_state == ST_IDLE) | w_rsp_hs);
  assign w_head   = r_mem[r_rd_ptr];

  // FIFO data array: written on push only
  // NOTE: the storage array has no reset; only pointers and count define
  // validity, so clearing the data would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_cin};
  end

  // FIFO pointers and occupancy count
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sequencer: load ALU inputs, wait SETTLE cycles, capture, hand back result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_f          <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_op     <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_a      <= w_head.a;
            r_b      <= w_head.b;
            r_op     <= w_head.op;
            r_f      <= w_head.cin;
            r_settle <= SW'(SETTLE);
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_settle <= r_settle - SW'(1);
          if (r_settle == SW'(1)) begin
            r_rsp_result <= R;
            r_rsp_cout   <= D;
            r_rsp_op     <= r_op;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            if (w_pop) begin
              r_a      <= w_head.a;
              r_b      <= w_head.b;
              r_op     <= w_head.op;
              r_f      <= w_head.cin;
              r_settle <= SW'(SETTLE);
              r_state  <= ST_WAIT;
            end else begin
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign op         = r_op;
  assign F          = r_f;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_op     = r_rsp_op;
  assign op_count   = r_op_count;
  assign busy       = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Testbench for alu_cmd_driver: a behavioural ALU on the ALU ports, plus a
// queue of expected responses computed from each accepted command.
module tb_alu_cmd_driver;

  typedef struct packed {
    logic [7:0] r;
    logic       d;
    logic [3:0] op;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_cin;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic [7:0]  A, B, R;
  logic [3:0]  op;
  logic        F, D;
  logic        rsp_valid, rsp_ready, rsp_cout, busy;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_op;
  logic [15:0] op_count;

  // second instance with a longer settle time
  logic        c3_cmd_valid, c3_cmd_ready, c3_cmd_cin;
  logic [7:0]  c3_cmd_a, c3_cmd_b, c3_A, c3_B, c3_R;
  logic [3:0]  c3_cmd_op, c3_op;
  logic        c3_F, c3_D;
  logic        c3_rsp_valid, c3_rsp_ready, c3_rsp_cout, c3_busy;
  logic [7:0]  c3_rsp_result;
  logic [3:0]  c3_rsp_op;
  logic [15:0] c3_op_count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_count = 0;
  rsp_t exp_q[$];
  logic hs_flag;
  rsp_t hs_rsp;

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] o, input logic c);
    case (o)
      4'd0:    return {1'b0, a} + {1'b0, b} + 9'(c);
      4'd1:    return {1'b0, a & b};
      4'd2:    return {1'b0, a | b};
      4'd3:    return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, ~b} + 9'(c);
    endcase
  endfunction

  always_comb {D, R}       = alu_ref(A, B, op, F);
  always_comb {c3_D, c3_R} = alu_ref(c3_A, c3_B, c3_op, c3_F);

  alu_cmd_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .A(A), .B(B), .op(op), .F(F), .R(R), .D(D),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_op(rsp_op), .busy(busy), .op_count(op_count)
  );

  alu_cmd_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_a(c3_cmd_a),
    .cmd_b(c3_cmd_b), .cmd_op(c3_cmd_op), .cmd_cin(c3_cmd_cin),
    .A(c3_A), .B(c3_B), .op(c3_op), .F(c3_F), .R(c3_R), .D(c3_D),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_result(c3_rsp_result),
    .rsp_cout(c3_rsp_cout), .rsp_op(c3_rsp_op), .busy(c3_busy), .op_count(c3_op_count)
  );

  function automatic rsp_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic rand_cmd();
    cmd_a   = 8'($urandom);
    cmd_b   = 8'($urandom);
    cmd_op  = 4'($urandom_range(0, 5));
    cmd_cin = 1'($urandom);
  endtask

  // Advance one clock; record accepted commands and observed handshakes.
  task automatic step();
    logic acc;
    logic hs;
    rsp_t e;
    rsp_t g;
    acc = cmd_valid && cmd_ready;
    hs  = rsp_valid && rsp_ready;
    g   = {rsp_result, rsp_cout, rsp_op};
    e   = 'x;
    if (acc) begin
      {e.d, e.r} = alu_ref(cmd_a, cmd_b, cmd_op, cmd_cin);
      e.op = cmd_op;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) exp_q.push_back(e);
    hs_flag = hs;
    hs_rsp  = g;
    if (hs) exp_count++;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cmd_ready, A, B, op, F, rsp_valid, rsp_result, rsp_cout, rsp_op, busy, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {cmd_ready, A, B, op, F, rsp_valid, rsp_result, rsp_cout, rsp_op, busy, op_count});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_single();
    rsp_t e;
    rsp_ready = 1'b0;
    cmd_a = 8'd3; cmd_b = 8'd1; cmd_op = 4'd0; cmd_cin = 1'b0; cmd_valid = 1'b1;
    step();  // edge 0: accept
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got rsp_valid=%b want 0", rsp_valid);
    end
    step();  // edge 1: load
    checks++;
    if ({A, B, op, F} !== {8'd3, 8'd1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_load: got A=%0d B=%0d op=%0d F=%b want 3 1 0 0", A, B, op, F);
    end
    step();  // edge 2: capture
    checks++;
    if ({rsp_valid, rsp_result, rsp_cout, rsp_op} !== {1'b1, 8'd4, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b r=%0d c=%b op=%0d want 1 4 0 0",
               rsp_valid, rsp_result, rsp_cout, rsp_op);
    end
    rsp_ready = 1'b1;
    step();  // handshake
    rsp_ready = 1'b0;
    e = pop_exp();
    checks++;
    if (!hs_flag || hs_rsp !== e) begin
      errors++;
      $display("FAIL single_hs: got hs=%b rsp=%h want hs=1 rsp=%h", hs_flag, hs_rsp, e);
    end
    checks++;
    if ({op_count, rsp_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_count: got cnt=%0d v=%b busy=%b want 1 0 0", op_count, rsp_valid, busy);
    end
  endtask

  task automatic test_full();
    rsp_t held;
    rsp_t cur;
    rsp_t e;
    logic held_ok;
    int   last_hs;
    int   n_hs;
    held_ok = 1'b0;
    held    = '0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    rand_cmd();
    for (int i = 0; i < 12; i++) begin
      step();
      rand_cmd();
      if (rsp_valid) begin
        cur = {rsp_result, rsp_cout, rsp_op};
        if (!held_ok) begin
          held    = cur;
          held_ok = 1'b1;
        end else begin
          checks++;
          if (cur !== held) begin
            errors++;
            $display("FAIL full_hold: got %h want %h", cur, held);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 5 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_accept: got accepted=%0d ready=%b busy=%b want 5 0 1",
               exp_q.size(), cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n_hs = 0;
    last_hs = -1;
    for (int i = 0; i < 30 && n_hs < 5; i++) begin
      step();
      if (hs_flag) begin
        e = pop_exp();
        checks++;
        if (hs_rsp !== e) begin
          errors++;
          $display("FAIL full_drain_data: got %h want %h", hs_rsp, e);
        end
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 2) begin
            errors++;
            $display("FAIL full_drain_rate: got gap=%0d want 2", cyc - last_hs);
          end
        end
        last_hs = cyc;
        n_hs++;
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (n_hs != 5 || op_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL full_drain_count: got hs=%0d cnt=%0d want 5 %0d", n_hs, op_count, exp_count);
    end
  endtask

  task automatic test_carry();
    rsp_t e;
    rsp_ready = 1'b0;
    cmd_a = 8'd128; cmd_b = 8'd128; cmd_op = 4'd0; cmd_cin = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checks++;
    if ({rsp_valid, rsp_result, rsp_cout} !== {1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL carry_out: got v=%b r=%0d c=%b want 1 0 1", rsp_valid, rsp_result, rsp_cout);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    e = pop_exp();
    cmd_a = 8'd4; cmd_b = 8'd5; cmd_op = 4'd5; cmd_cin = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();  // now in WAIT
    checks++;
    if ({F, op} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL carry_in_port: got F=%b op=%0d want 1 5", F, op);
    end
    step();
    e = exp_q[0];
    checks++;
    if ({rsp_valid, rsp_op, rsp_result, rsp_cout} !== {1'b1, 4'd5, e.r, e.d}) begin
      errors++;
      $display("FAIL carry_rsp_op: got v=%b op=%0d r=%0d c=%b want 1 5 %0d %b",
               rsp_valid, rsp_op, rsp_result, rsp_cout, e.r, e.d);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    e = pop_exp();
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    logic acc;
    int   n_acc;
    int   n_hs;
    int   last_hs;
    n_acc = 0;
    n_hs = 0;
    last_hs = -1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    rand_cmd();
    for (int i = 0; i < 100 && n_hs < 10; i++) begin
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) n_acc++;
      if (n_acc == 10) cmd_valid = 1'b0;
      rand_cmd();
      if (hs_flag) begin
        e = pop_exp();
        checks++;
        if (hs_rsp !== e) begin
          errors++;
          $display("FAIL b2b_data: got %h want %h", hs_rsp, e);
        end
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 2) begin
            errors++;
            $display("FAIL b2b_gap: got gap=%0d want 2", cyc - last_hs);
          end
        end
        last_hs = cyc;
        n_hs++;
      end
      if (n_hs < 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy: got busy=%b want 1 at cycle %0d", busy, cyc);
        end
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (n_hs != 10 || busy !== 1'b0 || op_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL b2b_end: got hs=%0d busy=%b cnt=%0d want 10 0 %0d", n_hs, busy, op_count, exp_count);
    end
  endtask

  task automatic test_settle3_latency();
    int   lat;
    logic [8:0] e;
    c3_cmd_a = 8'($urandom); c3_cmd_b = 8'($urandom);
    c3_cmd_op = 4'd0; c3_cmd_cin = 1'b1;
    e = alu_ref(c3_cmd_a, c3_cmd_b, c3_cmd_op, c3_cmd_cin);
    c3_rsp_ready = 1'b0;
    checks++;
    if (c3_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL s3_ready: got %b want 1", c3_cmd_ready);
    end
    c3_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    c3_cmd_valid = 1'b0;
    lat = 0;
    while (c3_rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL s3_latency: got %0d want 4", lat);
    end
    checks++;
    if ({c3_rsp_cout, c3_rsp_result} !== e) begin
      errors++;
      $display("FAIL s3_result: got %h want %h", {c3_rsp_cout, c3_rsp_result}, e);
    end
    c3_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    c3_rsp_ready = 1'b0;
    checks++;
    if ({c3_op_count, c3_rsp_valid} !== {16'd1, 1'b0}) begin
      errors++;
      $display("FAIL s3_count: got cnt=%0d v=%b want 1 0", c3_op_count, c3_rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    rsp_ready = 1'b0;
    cmd_a = 8'hA5; cmd_b = 8'h5A; cmd_op = 4'd3; cmd_cin = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();  // loaded, now in WAIT
    checks++;
    if (A !== 8'hA5) begin
      errors++;
      $display("FAIL rstmid_preload: got A=%h want a5", A);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, A, B, op, F, rsp_valid, rsp_result, rsp_cout, rsp_op, busy, op_count} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got %h want 0",
               {cmd_ready, A, B, op, F, rsp_valid, rsp_result, rsp_cout, rsp_op, busy, op_count});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_count = 0;
    rsp_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen_valid || cmd_ready !== 1'b1 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_after: got stale=%b ready=%b cnt=%0d want 0 1 0",
               seen_valid, cmd_ready, op_count);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_cin = 1'b0; rsp_ready = 1'b0;
    c3_cmd_valid = 1'b0; c3_cmd_a = '0; c3_cmd_b = '0; c3_cmd_op = '0; c3_cmd_cin = 1'b0;
    c3_rsp_ready = 1'b0;
    hs_flag = 1'b0;
    hs_rsp = '0;
    test_reset();
    test_single();
    test_full();
    test_carry();
    test_back_to_back();
    test_settle3_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
